// File: rtl/timer_multi_ch.sv
// timer_multi_ch
//   N_CH independent up/down counters sharing one free-running prescaler and
//   one zero-wait-state APB slave. Each channel has four registers:
//     0 TDR  (RW, DW bits)  reload / load value
//     1 TCR  (RW, [7:0])    [7] load, [6] auto-reload, [5] count down,
//                           [4] enable, [3] irq enable, [1:0] clock select
//                           (bit 2 reserved, reads 0)
//     2 TSR  (RW1C, [1:0])  [0] OVF, [1] UDF
//     3 TCNT (RO, DW bits)  live count
//   Ports:
//     clk, rst        clock and synchronous active-high reset
//     psel, penable,  APB control; paddr[7:2] selects the channel,
//     pwrite, paddr   paddr[1:0] selects the register
//     pwdata/prdata   write / read data (prdata is 0 outside read access)
//     pready          high in every access phase (no wait states)
//     pslverr         high in an access phase to an unmapped channel
//     irq[N_CH]       level interrupt, TCR[3] & (OVF | UDF)
module timer_multi_ch #(
  parameter int N_CH = 4,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [7:0]      paddr,
  input  logic [DW-1:0]   pwdata,
  output logic [DW-1:0]   prdata,
  output logic            pready,
  output logic            pslverr,
  output logic [N_CH-1:0] irq
);

  localparam logic [1:0]    REG_TDR  = 2'd0;
  localparam logic [1:0]    REG_TCR  = 2'd1;
  localparam logic [1:0]    REG_TSR  = 2'd2;
  localparam logic [1:0]    REG_TCNT = 2'd3;
  localparam logic [7:0]    TCR_MASK = 8'hFB;
  localparam logic [5:0]    NCH      = 6'(N_CH);
  localparam logic [DW-1:0] ONE      = DW'(1);

  logic [DW-1:0] tdr  [N_CH];
  logic [7:0]    tcr  [N_CH];
  logic [1:0]    tsr  [N_CH];
  logic [DW-1:0] tcnt [N_CH];
  logic [3:0]    psc;

  logic          access;
  logic [5:0]    ch_sel;
  logic [1:0]    reg_sel;
  logic          mapped;

  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] ovf;
  logic [N_CH-1:0] udf;
  logic [N_CH-1:0] we;
  logic [DW-1:0]   cnt_nxt [N_CH];
  logic [1:0]      w1c     [N_CH];

  assign access  = psel & penable;
  assign ch_sel  = paddr[7:2];
  assign reg_sel = paddr[1:0];
  assign mapped  = (ch_sel < NCH);

  // Per-channel next state. Everything here looks only at the current
  // (pre-write) TCR, so a TCR write and a tick on the same edge behave as
  // if the tick came first.
  always_comb begin
    tick = '0;
    ovf  = '0;
    udf  = '0;
    we   = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      cnt_nxt[c] = tcnt[c];
      w1c[c]     = 2'b00;

      case (tcr[c][1:0])
        2'd0:    tick[c] = psc[0];
        2'd1:    tick[c] = &psc[1:0];
        2'd2:    tick[c] = &psc[2:0];
        default: tick[c] = &psc;
      endcase

      if (tcr[c][7]) begin
        cnt_nxt[c] = tdr[c];
      end else if (tcr[c][4] && tick[c]) begin
        if (tcr[c][5]) begin
          if (tcnt[c] == '0) begin
            udf[c]     = 1'b1;
            cnt_nxt[c] = tcr[c][6] ? tdr[c] : '1;
          end else begin
            cnt_nxt[c] = tcnt[c] - ONE;
          end
        end else begin
          if (tcnt[c] == '1) begin
            ovf[c]     = 1'b1;
            cnt_nxt[c] = tcr[c][6] ? tdr[c] : '0;
          end else begin
            cnt_nxt[c] = tcnt[c] + ONE;
          end
        end
      end

      we[c] = access & pwrite & (ch_sel == 6'(c));
      if (we[c] && reg_sel == REG_TSR) begin
        w1c[c] = pwdata[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        tdr[c]  <= '0;
        tcr[c]  <= '0;
        tsr[c]  <= '0;
        tcnt[c] <= '0;
      end
    end else begin
      psc <= psc + 4'd1;
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (we[c] && reg_sel == REG_TDR) begin
          tdr[c] <= pwdata;
        end
        if (we[c] && reg_sel == REG_TCR) begin
          tcr[c] <= pwdata[7:0] & TCR_MASK;
        end
        // Clear first, then OR in the hardware set so a same-edge set wins.
        tsr[c]  <= (tsr[c] & ~w1c[c]) | {udf[c], ovf[c]};
        tcnt[c] <= cnt_nxt[c];
      end
    end
  end

  always_comb begin
    prdata  = '0;
    pready  = access;
    pslverr = access & ~mapped;
    if (access && !pwrite) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (ch_sel == 6'(c)) begin
          case (reg_sel)
            REG_TDR:  prdata = tdr[c];
            REG_TCR:  prdata = DW'(tcr[c]);
            REG_TSR:  prdata = DW'(tsr[c]);
            REG_TCNT: prdata = tcnt[c];
            default:  prdata = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      irq[c] = tcr[c][3] & (|tsr[c]);
    end
  end

endmodule

// File: tb/tb_timer_multi_ch.sv
module tb_timer_multi_ch;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel_a, psel_b, penable, pwrite;
  logic [7:0]  paddr;
  logic [15:0] pwdata;

  logic [7:0]  prdata_a;
  logic        pready_a, pslverr_a;
  logic [3:0]  irq_a;
  logic [15:0] prdata_b;
  logic        pready_b, pslverr_b;
  logic [1:0]  irq_b;

  always #5 clk = ~clk;

  timer_multi_ch #(.N_CH(4), .DW(8)) dut_a (
    .clk(clk), .rst(rst), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata[7:0]), .prdata(prdata_a), .pready(pready_a),
    .pslverr(pslverr_a), .irq(irq_a)
  );

  timer_multi_ch #(.N_CH(2), .DW(16)) dut_b (
    .clk(clk), .rst(rst), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b), .irq(irq_b)
  );

  int npass = 0;
  int ntotal = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One zero-wait APB transfer; b selects dut_b (16-bit, 2 ch) over dut_a.
  task automatic apb(input bit b, input bit wr, input logic [7:0] a, input logic [15:0] wd,
                     output logic [15:0] rd, output logic err);
    @(negedge clk);
    psel_a = !b; psel_b = b; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rd  = b ? prdata_b : {8'h00, prdata_a};
    err = b ? pslverr_b : pslverr_a;
    chk("pready", b ? pready_b : pready_a, 32'd1);
    @(posedge clk);
    #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input bit b, input logic [7:0] a, input logic [15:0] d);
    logic [15:0] r;
    logic e;
    apb(b, 1'b1, a, d, r, e);
  endtask

  task automatic rdchk(input bit b, input logic [7:0] a, input logic [15:0] exp, input string nm);
    logic [15:0] r;
    logic e;
    apb(b, 1'b0, a, 16'h0000, r, e);
    chk(nm, r, exp);
    chk({nm, "_err"}, e, 32'd0);
  endtask

  // Hold a read access phase open so prdata can be sampled every cycle.
  task automatic watch_on(input bit b, input logic [7:0] a);
    @(negedge clk);
    psel_a = !b; psel_b = b; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1;
  endtask

  task automatic watch_off();
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    bit         err;
  } vec_t;

  vec_t tbl [21];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    logic        e;
    logic [7:0]  d;
    logic [7:0]  last [4];
    logic [15:0] prev;
    bit          found;
    int          n;

    rst = 1'b1; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;

    tbl[0]  = '{1'b1, 8'h01, 8'hFF, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h01, 8'h00, 8'hFB, 1'b0};
    tbl[2]  = '{1'b1, 8'h00, 8'hA5, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 8'h00, 8'hA5, 1'b0};
    tbl[4]  = '{1'b0, 8'h03, 8'h00, 8'hA5, 1'b0};
    tbl[5]  = '{1'b1, 8'h05, 8'h6C, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h05, 8'h00, 8'h68, 1'b0};
    tbl[7]  = '{1'b0, 8'h01, 8'h00, 8'hFB, 1'b0};
    tbl[8]  = '{1'b0, 8'h09, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 8'h0A, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 8'h0D, 8'h04, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 8'h0D, 8'h00, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 8'h0E, 8'h00, 8'h00, 1'b0};
    tbl[13] = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1};
    tbl[14] = '{1'b1, 8'h10, 8'h77, 8'h00, 1'b1};
    tbl[15] = '{1'b1, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[16] = '{1'b0, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[17] = '{1'b1, 8'h03, 8'h55, 8'h00, 1'b0};
    tbl[18] = '{1'b0, 8'h03, 8'h00, 8'hA5, 1'b0};
    tbl[19] = '{1'b0, 8'h02, 8'h00, 8'h00, 1'b0};
    tbl[20] = '{1'b0, 8'h06, 8'h00, 8'h00, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_prdata_a", prdata_a, 32'd0);
    chk("rst_pready_a", pready_a, 32'd0);
    chk("rst_pslverr_a", pslverr_a, 32'd0);
    chk("rst_irq_a", irq_a, 32'd0);
    chk("rst_prdata_b", prdata_b, 32'd0);
    chk("rst_pready_b", pready_b, 32'd0);
    chk("rst_irq_b", irq_b, 32'd0);
    rdchk(1'b0, 8'h00, 16'h0000, "rst_tdr");
    rdchk(1'b0, 8'h01, 16'h0000, "rst_tcr");
    rdchk(1'b0, 8'h02, 16'h0000, "rst_tsr");
    rdchk(1'b0, 8'h03, 16'h0000, "rst_tcnt");

    // Register access table
    foreach (tbl[i]) begin
      apb(1'b0, tbl[i].wr, tbl[i].addr, {8'h00, tbl[i].data}, r, e);
      if (!tbl[i].wr) chk($sformatf("tbl%0d_data", i), r, {24'h0, tbl[i].exp});
      chk($sformatf("tbl%0d_err", i), e, {31'h0, tbl[i].err});
    end

    // Random TCR write/readback on every channel
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 100; i++) begin
        d = 8'($urandom);
        wr(1'b0, 8'(c * 4 + 1), {8'h00, d});
        rdchk(1'b0, 8'(c * 4 + 1), {8'h00, d & 8'hFB}, "tcr_rand");
        last[c] = d;
      end
    end
    for (int c = 0; c < 4; c++) rdchk(1'b0, 8'(c * 4 + 1), {8'h00, last[c] & 8'hFB}, "tcr_keep");
    do_reset();

    // Load then up-count through the wrap
    wr(1'b0, 8'h00, 16'h00FD);
    wr(1'b0, 8'h01, 16'h0080);
    rdchk(1'b0, 8'h03, 16'h00FD, "load_tcnt");
    wr(1'b0, 8'h01, 16'h0010);
    watch_on(1'b0, 8'h03);
    found = 1'b0; n = 0; prev = 16'hDEAD;
    while (!found && n < 16) begin
      if (prdata_a == 8'h00) found = 1'b1;
      else begin
        prev = {8'h00, prdata_a};
        @(negedge clk); #1;
        n++;
      end
    end
    watch_off();
    chk("up_wrap_seen", found, 32'd1);
    chk("up_wrap_prev", prev, 32'h00FF);
    wr(1'b0, 8'h01, 16'h0000);
    rdchk(1'b0, 8'h02, 16'h0001, "up_ovf_tsr");

    // Auto-reload down-count with interrupt on channel 1
    wr(1'b0, 8'h04, 16'h0003);
    wr(1'b0, 8'h05, 16'h0080);
    wr(1'b0, 8'h05, 16'h0078);
    watch_on(1'b0, 8'h07);
    found = 1'b0; n = 0; prev = 16'hDEAD;
    while (!found && n < 24) begin
      if (irq_a[1]) found = 1'b1;
      else begin
        prev = {8'h00, prdata_a};
        @(negedge clk); #1;
        n++;
      end
    end
    chk("dn_irq_seen", found, 32'd1);
    chk("dn_reload", prdata_a, 32'h03);
    chk("dn_prev", prev, 32'h0000);
    watch_off();
    rdchk(1'b0, 8'h06, 16'h0002, "dn_udf_tsr");
    wr(1'b0, 8'h06, 16'h0002);
    chk("dn_irq_clr", irq_a[1], 32'd0);
    rdchk(1'b0, 8'h06, 16'h0000, "dn_tsr_clr");
    wr(1'b0, 8'h05, 16'h0000);

    // W1C against a same-edge OVF set (div16, auto-reload from FF: OVF every tick)
    wr(1'b0, 8'h08, 16'h00FF);
    wr(1'b0, 8'h09, 16'h0080);
    wr(1'b0, 8'h09, 16'h005B);
    found = 1'b0; n = 0;
    while (!found && n < 40) begin
      @(negedge clk); #1;
      if (irq_a[2]) found = 1'b1;
      n++;
    end
    chk("col_irq_seen", found, 32'd1);
    // Place the TSR write's access edge exactly 16 clocks after that tick.
    repeat (13) @(negedge clk);
    wr(1'b0, 8'h0A, 16'h0001);
    rdchk(1'b0, 8'h0A, 16'h0001, "w1c_collide");
    wr(1'b0, 8'h0A, 16'h0001);
    rdchk(1'b0, 8'h0A, 16'h0000, "w1c_clear");
    chk("w1c_irq", irq_a[2], 32'd0);
    wr(1'b0, 8'h09, 16'h0000);

    // Unmapped channel on the two-channel instance
    apb(1'b1, 1'b0, 8'h0C, 16'h0000, r, e);
    chk("unmap_rd_data", r, 32'd0);
    chk("unmap_rd_err", e, 32'd1);
    apb(1'b1, 1'b1, 8'h0C, 16'h1234, r, e);
    chk("unmap_wr_err", e, 32'd1);
    rdchk(1'b1, 8'h05, 16'h0000, "b_ch1_tcr");

    // 16-bit wrap
    wr(1'b1, 8'h00, 16'hFFFF);
    wr(1'b1, 8'h01, 16'h0080);
    rdchk(1'b1, 8'h03, 16'hFFFF, "wide_load");
    wr(1'b1, 8'h01, 16'h0018);
    watch_on(1'b1, 8'h03);
    found = 1'b0; n = 0;
    while (!found && n < 10) begin
      if (prdata_b == 16'h0000) found = 1'b1;
      else begin
        @(negedge clk); #1;
        n++;
      end
    end
    chk("wide_wrap_seen", found, 32'd1);
    chk("wide_irq", irq_b[0], 32'd1);
    watch_off();
    rdchk(1'b1, 8'h02, 16'h0001, "wide_ovf_tsr");

    // Reset in the access phase of a write, while channel 0 is counting
    @(negedge clk);
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 16'h1234;
    @(negedge clk);
    penable = 1'b1; rst = 1'b1;
    @(negedge clk);
    psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
    #1;
    chk("mrst_pready", pready_b, 32'd0);
    chk("mrst_pslverr", pslverr_b, 32'd0);
    chk("mrst_prdata", prdata_b, 32'd0);
    chk("mrst_irq", irq_b, 32'd0);
    rdchk(1'b1, 8'h00, 16'h0000, "mrst_tdr");
    rdchk(1'b1, 8'h01, 16'h0000, "mrst_tcr");
    rdchk(1'b1, 8'h02, 16'h0000, "mrst_tsr");
    rdchk(1'b1, 8'h03, 16'h0000, "mrst_tcnt");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/timer_multi_ch.md
# timer_multi_ch

Multi-channel, width-parametrised successor to the single 8-bit timer. It provides N_CH independent up/down counters behind one APB slave. Each channel has a data register (TDR), control register (TCR), status register (TSR) and a read-only count register (TCNT). New over the single timer: auto-reload, a per-channel interrupt, a readable live count and error response on unmapped addresses. The block sits on the peripheral APB bus next to the existing timer; interrupts go to the interrupt controller.

## Interface
- N_CH, 4, number of channels (1..8)
- DW, 8, counter and bus data width (8..32); TCR/TSR use bits [7:0], upper bits read 0
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  8  byte-free register index: [7:2] channel, [1:0] register
- pwdata  in  DW  write data
- prdata  out  DW  read data, valid in the access phase
- pready  out  1  transfer complete
- pslverr  out  1  error response
- irq  out  N_CH  per-channel interrupt, level

## Operation
- Register offsets per channel: 0 TDR (RW, DW bits), 1 TCR (RW), 2 TSR (RW1C), 3 TCNT (RO).
- TCR bits: [7] load, [6] auto-reload, [5] count down, [4] enable, [3] irq enable, [1:0] clock select. Bit [2] is reserved; it ignores writes and reads 0. The readback mask is 8'hFB.
- TSR bits: [0] OVF, [1] UDF. Writing 1 clears a bit; writing 0 has no effect. Bits [7:2] read 0.
- Prescaler: a shared 4-bit free-running counter psc, reset to 0. A channel tick fires when psc[k:0] == all ones, with k = TCR[1:0]. This gives divide-by 2/4/8/16.
- Load: while TCR[7]=1, TCNT <= TDR every clock and counting is suppressed. Load is not self-clearing.
- Counting: with TCR[4]=1, TCR[7]=0 and a tick, TCNT steps by +1, or by -1 when TCR[5]=1.
- Overflow: an up step from all ones gives TCNT <= 0, or TDR if TCR[6]=1. OVF is set.
- Underflow: a down step from 0 gives TCNT <= all ones, or TDR if TCR[6]=1. UDF is set.
- irq[ch] = TCR[3] & (OVF | UDF).
- Unmapped channel (paddr[7:2] >= N_CH): pslverr=1, prdata=0, write ignored.
- A write to TCNT is ignored, with pslverr=0.
- Simultaneous hardware flag set and W1C on the same clock: set wins.
- Simultaneous TCR write and count tick: the tick uses the TCR value from before the write.

## Timing
- Reset values: TDR=0, TCR=0, TSR=0, TCNT=0, psc=0, prdata=0, pready=0, pslverr=0, irq=0.
- APB transfers have zero wait states.
  - Setup phase: psel=1, penable=0.
  - Access phase: psel=1, penable=1, with pready=1 in the same cycle.
  - pready and pslverr are 0 outside the access phase.
- Writes take effect at the clock edge ending the access phase. A read in the next transfer returns the new value.
- prdata is a combinational mux of the current register state during the access phase.
- TCNT changes one clock after the qualifying tick edge. OVF/UDF and irq assert in that same cycle.
- Load latency: TCNT == TDR one clock after the TCR write with bit7=1.
- Reset mid-transfer: the transfer is abandoned, no register is updated and pready drops to 0 the following cycle.

## Test plan
- TCR write/read: 100 random wdata per channel, N_CH=4 -> rdata == wdata & 8'hFB. Writing TDR=8'hA5 -> reads 8'hA5. TCR/TSR on other channels stay unchanged.
- Load and up-count, DW=8: TDR=8'hFD, TCR=8'h80, then TCR=8'h10 (div2). After 6 clocks -> TCNT wraps to 8'h00, OVF=1, TSR reads 8'h01.
- Auto-reload down-count with irq: TDR=8'h03, TCR=8'h80, then TCR=8'h78. On underflow, TCNT reloads 8'h03, UDF=1 and irq[ch]=1. Write TSR=8'h02 -> irq=0 next cycle.
- W1C vs set collision: a TSR write of 8'h01 in the cycle OVF re-asserts -> OVF reads 1.
- Unmapped and read-only: N_CH=2, paddr=8'h0C -> pslverr=1 and prdata=0. A write to TCNT -> TCNT unchanged and pslverr=0.
- Wide and reset: DW=16, TDR=16'hFFFF, up-count -> wraps to 16'h0000 with OVF. Assert rst mid-count -> all registers 0 one clock later.
